// File: rtl/tile_ram_writer.sv
// Host-side write port for the 32x32 tile RAM: buffers byte writes and runs bulk clears,
// touching the RAM only while the display is blanked.
module tile_ram_writer #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned DATA_W     = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        display_on,
    input  logic [ADDR_W-1:0]           disp_addr,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [ADDR_W-1:0]           cmd_addr,
    input  logic [DATA_W-1:0]           cmd_data,
    input  logic                        clear_req,
    input  logic [DATA_W-1:0]           clear_value,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic [ADDR_W-1:0]           ram_addr,
    output logic [DATA_W-1:0]           ram_din,
    output logic                        ram_we
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] CLEAR = 1'b1;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } cmd_t;

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic [DATA_W-1:0] fill_q, fill_d;

    cmd_t              fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  head_q, tail_q;
    logic [CNT_W-1:0]  count_q;
    logic              push;
    logic              pop;
    cmd_t              head;

    // Ready is forced low during reset so nothing is accepted while the block is held.
    assign cmd_ready  = reset && (state_q == IDLE) && (count_q < CNT_W'(FIFO_DEPTH));
    assign push       = cmd_valid && cmd_ready;
    assign head       = fifo_mem[head_q];
    assign fifo_count = count_q;
    assign busy       = (state_q == CLEAR) || (count_q != '0);

    // Command FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                tail_q <= tail_q + PTR_W'(1);
            end
            if (pop) begin
                head_q <= head_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Payload storage needs no reset; only slots behind valid pointers are ever read.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[tail_q] <= '{addr: cmd_addr, data: cmd_data};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            clr_cnt_q <= '0;
            fill_q    <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            fill_q    <= fill_d;
        end
    end

    // Next state and RAM port mux; the display owns the address whenever nothing is written.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        fill_d    = fill_q;
        pop       = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = disp_addr;
        ram_din   = '0;

        case (state_q)
            IDLE: begin
                if (clear_req) begin
                    fill_d    = clear_value;
                    clr_cnt_d = '0;
                    state_d   = CLEAR;
                end else if (!display_on && (count_q != '0)) begin
                    ram_we   = 1'b1;
                    ram_addr = head.addr;
                    ram_din  = head.data;
                    pop      = 1'b1;
                end
            end
            CLEAR: begin
                if (!display_on) begin
                    ram_we    = 1'b1;
                    ram_addr  = clr_cnt_q;
                    ram_din   = fill_q;
                    clr_cnt_d = clr_cnt_q + ADDR_W'(1);
                    if (clr_cnt_q == '1) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: doc/tile_ram_writer.md
Name: tile_ram_writer

Overview:
- Upstream write port for the 32x32 byte tile RAM read by the digit-grid display stage.
- Accepts host write commands through a valid/ready handshake, buffers them in a small FIFO, and performs a bulk clear that fills all 1024 cells with one value.
- Owns the RAM address/write mux. The display read address passes through untouched while display_on=1. Writes happen only while display_on=0, so the display never reads a corrupted cell.

Parameters:
- FIFO_DEPTH, 4, number of buffered write commands; power of two, minimum 2.
- ADDR_W, 10, RAM address width ({row[4:0],col[4:0]}).
- DATA_W, 8, RAM data width.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset; 0 = reset.
- display_on  in  1  high during the visible raster, when the display owns the RAM.
- disp_addr  in  ADDR_W  display read address, {vpos[7:3],hpos[7:3]}.
- cmd_valid  in  1  host write command present.
- cmd_ready  out  1  block can accept a command this cycle.
- cmd_addr  in  ADDR_W  target cell.
- cmd_data  in  DATA_W  byte to store.
- clear_req  in  1  single-cycle pulse that requests a full-RAM fill.
- clear_value  in  DATA_W  fill byte; sampled on the accepted clear_req.
- busy  out  1  clear in progress or FIFO non-empty.
- fifo_count  out  clog2(FIFO_DEPTH)+1  entries currently queued.
- ram_addr  out  ADDR_W  address to the sync RAM.
- ram_din  out  DATA_W  write data to the RAM.
- ram_we  out  1  RAM write enable.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, FIFO empty, fifo_count=0, clear counter=0, fill register=0.
  - cmd_ready=0 while reset is asserted; busy=0, ram_we=0, ram_din=0.
  - ram_addr=disp_addr.
  - A reset mid-clear or mid-drain aborts the operation; queued commands are discarded.
- States: IDLE and CLEAR.
- Handshake and FIFO accounting:
  - A push happens when cmd_valid && cmd_ready.
  - cmd_ready = (state==IDLE) && (fifo_count<FIFO_DEPTH). It is low while the FIFO is full and throughout CLEAR.
  - Push and pop in the same cycle leave fifo_count unchanged. The FIFO is first-in, first-out.
- IDLE with display_on=0 and the FIFO non-empty:
  - ram_we=1 (combinational), ram_addr=head addr, ram_din=head data.
  - The head is popped at that clock edge: one write per cycle, zero added latency.
- IDLE, any other case:
  - ram_we=0, ram_addr=disp_addr, ram_din=0.
- IDLE with clear_req=1:
  - Latch clear_value, set clear counter=0, go to CLEAR next cycle.
  - No FIFO pop happens in that cycle. A push in the same cycle is still accepted if cmd_ready=1.
- CLEAR:
  - With display_on=0: ram_we=1, ram_addr=counter, ram_din=fill value, and the counter increments.
  - With display_on=1: ram_we=0, ram_addr=disp_addr, and the counter holds.
  - After the write to address 1023, return to IDLE; the counter wraps to 0.
  - clear_req is ignored while in CLEAR.
  - Commands queued before the clear are kept and drained after it, so they overwrite the fill.
- Timing: a full clear takes exactly 1024 write cycles with display_on=0; total duration stretches across active video.
- busy = (state==CLEAR) || (fifo_count!=0).
- Invariant: ram_we=1 never coincides with display_on=1, in any state.
- Address wrap: cmd_addr is used as-is, modulo 1024.

Test Plan:
- Reset with 2 commands queued and display_on=0 -> fifo_count=0, cmd_ready=0 while reset=0, ram_we never asserts, busy=0 after release.
- display_on=0; push (0x021,0x05), (0x3FF,0x09) back-to-back -> ram_we=1 on two consecutive cycles: addr 0x021/din 0x05, then addr 0x3FF/din 0x09; RAM readback matches.
- display_on=1; push 5 commands with FIFO_DEPTH=4 -> cmd_ready drops after the 4th push, fifo_count=4, ram_we=0, ram_addr tracks disp_addr; drop display_on -> 4 writes in order, then cmd_ready=1.
- clear_req with clear_value=0x07, display_on toggling 8 cycles high/8 low -> ram_we only in low windows, 1024 writes total, all cells read 0x07, busy falls after the write to addr 1023.
- Queue (0x100,0xAA), then clear_req with value 0x00 and display_on=0 -> the clear completes first, then addr 0x100 reads 0xAA and every other cell reads 0x00.
- Assert reset=0 midway through a clear (counter=500) -> state=IDLE, counter=0, ram_we=0 immediately; a new clear_req after release restarts from address 0.
